sdfm_host_sequencer: RTL and testbench

//  Bus master for the SDFM register port. On start it writes a fixed config set (CTL, INPARM0, DFPARM0, FCTL0).
//  It then services IRQ by reading the filter data register and clearing flags. Each sample goes out on a

---
 rtl/sdfm_ctrl_pkg.sv | 39 +++
 rtl/sdfm_bus_access.sv | 94 +++++++++
 rtl/sdfm_host_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_sdfm_host_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdfm_ctrl_pkg.sv
// Shared definitions for the SDFM host sequencer: register map, FSM encodings, config address table.
package sdfm_ctrl_pkg;

  localparam logic [15:0] A_CTL     = 16'h0700;
  localparam logic [15:0] A_FLGCLR  = 16'h0704;
  localparam logic [15:0] A_INPARM0 = 16'h0710;
  localparam logic [15:0] A_DFPARM0 = 16'h0714;
  localparam logic [15:0] A_FCTL0   = 16'h0718;
  localparam logic [15:0] A_DATA0   = 16'h073C;

  // Sequencing states of the host FSM
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_RUN_WAIT,
    ST_RD_DATA,
    ST_CLR_FLAG,
    ST_STOP_WR
  } seq_state_t;

  // Phases of one register-port access
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } bus_phase_t;

  // Address of configuration write number idx (issued in order 0..3)
  function automatic logic [15:0] cfg_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    return A_CTL;
      2'd1:    return A_INPARM0;
      2'd2:    return A_DFPARM0;
      default: return A_FCTL0;
    endcase
  endfunction

endpackage

// File: rtl/sdfm_bus_access.sv
// Single register-port access engine: SETUP, STROBE_CYC strobe cycles, HOLD.
// A new request is accepted while idle or in the HOLD cycle, so accesses can run back to back.
module sdfm_bus_access #(
  parameter int STROBE_CYC = 2
) (
  input  logic        EXTCLK,
  input  logic        EXTRSTn,
  input  logic        i_req,
  input  logic        i_rnw,
  input  logic [15:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_rd,
  output logic        o_wr,
  output logic [15:0] o_addr,
  output logic [31:0] o_wdata
);
  import sdfm_ctrl_pkg::*;

  localparam int CW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(STROBE_CYC - 1);

  bus_phase_t    r_phase;
  bus_phase_t    w_phase_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_rnw;
  logic [15:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          w_accept;
  logic          w_last;
  logic          w_strobe;

  assign w_accept = ((r_phase == PH_IDLE) || (r_phase == PH_HOLD)) && i_req;
  assign w_last   = (r_cnt == LAST_CNT);
  assign w_strobe = (r_phase == PH_STROBE);

  // Phase and strobe-counter state register
  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next phase: strobe stays high for STROBE_CYC cycles, then one hold cycle
  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    case (r_phase)
      PH_IDLE, PH_HOLD: w_phase_nxt = i_req ? PH_SETUP : PH_IDLE;
      PH_SETUP: begin
        w_phase_nxt = PH_STROBE;
        w_cnt_nxt   = '0;
      end
      PH_STROBE: begin
        if (w_last) w_phase_nxt = PH_HOLD;
        else        w_cnt_nxt   = r_cnt + CW'(1);
      end
      default: w_phase_nxt = PH_IDLE;
    endcase
  end

  // Latch the access on accept; capture read data on the last strobe cycle
  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      r_rnw   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_rnw   <= i_rnw;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      if (w_strobe && w_last && r_rnw) r_rdata <= i_rdata;
    end
  end

  assign o_rd    = w_strobe && r_rnw;
  assign o_wr    = w_strobe && !r_rnw;
  assign o_addr  = r_addr;
  assign o_wdata = o_wr ? r_wdata : 32'h0;
  assign o_done  = (r_phase == PH_HOLD);
  assign o_rdata = r_rdata;

endmodule

// File: rtl/sdfm_host_sequencer.sv
// SDFM register-port master: writes the config set on start, services IRQ by reading
// the filter data and clearing flags, streams samples out, disables the filter on stop.
module sdfm_host_sequencer #(
  parameter logic [31:0] CFG_CTL     = 32'h0,
  parameter logic [31:0] CFG_INPARM0 = 32'h0,
  parameter logic [31:0] CFG_DFPARM0 = 32'h0,
  parameter logic [31:0] CFG_FCTL0   = 32'h0,
  parameter logic [31:0] FCTL0_OFF   = 32'h0,
  parameter logic [31:0] FLGCLR_VAL  = 32'hFFFF_FFFF,
  parameter int          STROBE_CYC  = 2
) (
  input  logic        EXTCLK,
  input  logic        EXTRSTn,
  input  logic        start,
  input  logic        stop,
  input  logic        IRQ,
  output logic        RD,
  output logic        WR,
  output logic [15:0] ADDR,
  output logic [31:0] WDATA,
  input  logic [31:0] RDATA,
  output logic [31:0] smp_data,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic        busy,
  output logic        running,
  output logic [7:0]  overrun_cnt
);
  import sdfm_ctrl_pkg::*;

  seq_state_t  r_state;
  seq_state_t  w_state_nxt;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_nxt;
  logic        r_stop_pend;
  logic        w_stop_pend_nxt;
  logic        r_blank;
  logic        w_blank_nxt;
  logic        w_take_stop;
  logic        w_req;
  logic        w_rnw;
  logic [15:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_done;
  logic [31:0] w_rdata;
  logic        w_deliver;
  logic        w_run_set;
  logic        w_run_clr;
  logic        r_running;
  logic        r_smp_valid;
  logic [31:0] r_smp_data;
  logic [7:0]  r_ovr;

  // Write value for configuration step idx
  function automatic logic [31:0] cfg_data(input logic [1:0] idx);
    case (idx)
      2'd0:    return CFG_CTL;
      2'd1:    return CFG_INPARM0;
      2'd2:    return CFG_DFPARM0;
      default: return CFG_FCTL0;
    endcase
  endfunction

  sdfm_bus_access #(.STROBE_CYC(STROBE_CYC)) u_bus (
    .EXTCLK  (EXTCLK),
    .EXTRSTn (EXTRSTn),
    .i_req   (w_req),
    .i_rnw   (w_rnw),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .i_rdata (RDATA),
    .o_done  (w_done),
    .o_rdata (w_rdata),
    .o_rd    (RD),
    .o_wr    (WR),
    .o_addr  (ADDR),
    .o_wdata (WDATA)
  );

  // Sequencer state, config index, pending stop and post-clear IRQ blanking
  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      r_state     <= ST_IDLE;
      r_idx       <= 2'd0;
      r_stop_pend <= 1'b0;
      r_blank     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_stop_pend <= w_stop_pend_nxt;
      r_blank     <= w_blank_nxt;
    end
  end

  assign w_take_stop = stop || r_stop_pend;

  // Next state and access launch; a request is issued on the cycle the next access must start
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_blank_nxt     = 1'b0;
    w_stop_pend_nxt = r_stop_pend ||
                      (stop && ((r_state == ST_CFG) || (r_state == ST_RD_DATA) ||
                                (r_state == ST_CLR_FLAG)));
    w_req           = 1'b0;
    w_rnw           = 1'b0;
    w_addr          = A_CTL;
    w_wdata         = 32'h0;
    w_deliver       = 1'b0;
    w_run_set       = 1'b0;
    w_run_clr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_CFG;
          w_idx_nxt   = 2'd0;
          w_req       = 1'b1;
          w_addr      = cfg_addr(2'd0);
          w_wdata     = cfg_data(2'd0);
        end
      end
      ST_CFG: begin
        if (w_done) begin
          if (r_idx == 2'd3) begin
            w_state_nxt = ST_RUN_WAIT;
            w_run_set   = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 2'd1;
            w_req     = 1'b1;
            w_addr    = cfg_addr(r_idx + 2'd1);
            w_wdata   = cfg_data(r_idx + 2'd1);
          end
        end
      end
      ST_RUN_WAIT: begin
        // stop has priority over a simultaneous IRQ
        if (w_take_stop) begin
          w_state_nxt     = ST_STOP_WR;
          w_stop_pend_nxt = 1'b0;
          w_req           = 1'b1;
          w_addr          = A_FCTL0;
          w_wdata         = FCTL0_OFF;
        end else if (IRQ && !r_blank) begin
          w_state_nxt = ST_RD_DATA;
          w_req       = 1'b1;
          w_rnw       = 1'b1;
          w_addr      = A_DATA0;
        end
      end
      ST_RD_DATA: begin
        if (w_done) begin
          w_state_nxt = ST_CLR_FLAG;
          w_req       = 1'b1;
          w_addr      = A_FLGCLR;
          w_wdata     = FLGCLR_VAL;
        end
      end
      ST_CLR_FLAG: begin
        if (w_done) begin
          // IRQ is still high until the clear propagates: ignore it for one cycle
          w_state_nxt = ST_RUN_WAIT;
          w_blank_nxt = 1'b1;
          w_deliver   = 1'b1;
        end
      end
      ST_STOP_WR: begin
        if (w_done) begin
          w_state_nxt = ST_IDLE;
          w_run_clr   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Running flag, sample output register and saturating overrun counter
  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      r_running   <= 1'b0;
      r_smp_valid <= 1'b0;
      r_smp_data  <= '0;
      r_ovr       <= '0;
    end else begin
      if (w_run_set)      r_running <= 1'b1;
      else if (w_run_clr) r_running <= 1'b0;
      if (w_deliver && !r_smp_valid) begin
        r_smp_data  <= w_rdata;
        r_smp_valid <= 1'b1;
      end else begin
        if (w_deliver && (r_ovr != 8'hFF)) r_ovr <= r_ovr + 8'd1;
        if (r_smp_valid && smp_ready)      r_smp_valid <= 1'b0;
      end
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign running     = r_running;
  assign smp_valid   = r_smp_valid;
  assign smp_data    = r_smp_data;
  assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_sdfm_host_sequencer.sv
// Testbench for sdfm_host_sequencer: directed scenarios plus random traffic against a
// behavioural model of the register sequencing.
module tb_sdfm_host_sequencer;

  localparam int          S     = 2;
  localparam int          LASTT = S + 1;
  localparam logic [31:0] P_CTL = 32'hC710_0001;
  localparam logic [31:0] P_INP = 32'h0000_0A5A;
  localparam logic [31:0] P_DFP = 32'h0123_0456;
  localparam logic [31:0] P_FC  = 32'h8000_0003;
  localparam logic [31:0] P_OFF = 32'h0000_0010;
  localparam logic [31:0] P_CLR = 32'hFFFF_FFFF;

  // model modes
  localparam int M_IDLE = 0, M_CFG = 1, M_WAIT = 2, M_READ = 3, M_CLEAR = 4, M_STOP = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, irq = 1'b0, smp_ready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        RD, WR, smp_valid, busy, running;
  logic [15:0] ADDR;
  logic [31:0] WDATA, smp_data;
  logic [7:0]  overrun_cnt;

  int checks = 0;
  int failures = 0;

  sdfm_host_sequencer #(
    .CFG_CTL(P_CTL), .CFG_INPARM0(P_INP), .CFG_DFPARM0(P_DFP), .CFG_FCTL0(P_FC),
    .FCTL0_OFF(P_OFF), .FLGCLR_VAL(P_CLR), .STROBE_CYC(S)
  ) dut (
    .EXTCLK(clk), .EXTRSTn(rst_n), .start(start), .stop(stop), .IRQ(irq),
    .RD(RD), .WR(WR), .ADDR(ADDR), .WDATA(WDATA), .RDATA(rdata),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .busy(busy), .running(running), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_mode, m_t, m_idx, m_ovr;
  bit          m_pend, m_blank, m_running, m_valid;
  logic [31:0] m_data, m_cap;

  function automatic logic [15:0] cfg_a(input int i);
    case (i) 0: return 16'h0700; 1: return 16'h0710; 2: return 16'h0714; default: return 16'h0718; endcase
  endfunction
  function automatic logic [31:0] cfg_d(input int i);
    case (i) 0: return P_CTL; 1: return P_INP; 2: return P_DFP; default: return P_FC; endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_t = 0; m_idx = 0; m_ovr = 0;
    m_pend = 0; m_blank = 0; m_running = 0; m_valid = 0;
    m_data = 32'h0; m_cap = 32'h0;
  endtask

  // Advance the model over one rising edge using this cycle's inputs
  task automatic model_step();
    bit nv, blank_now;
    nv = m_valid;
    if (m_valid && smp_ready) nv = 0;
    if (stop && (m_mode == M_CFG || m_mode == M_READ || m_mode == M_CLEAR)) m_pend = 1;
    blank_now = m_blank;
    m_blank = 0;
    case (m_mode)
      M_IDLE: if (start) begin m_mode = M_CFG; m_idx = 0; m_t = 0; end
      M_CFG: begin
        if (m_t == LASTT) begin
          if (m_idx == 3) begin m_mode = M_WAIT; m_running = 1; end
          else begin m_idx++; m_t = 0; end
        end else m_t++;
      end
      M_WAIT: begin
        if (stop || m_pend) begin m_mode = M_STOP; m_t = 0; m_pend = 0; end
        else if (irq && !blank_now) begin m_mode = M_READ; m_t = 0; end
      end
      M_READ: begin
        if (m_t == S) m_cap = rdata;
        if (m_t == LASTT) begin m_mode = M_CLEAR; m_t = 0; end else m_t++;
      end
      M_CLEAR: begin
        if (m_t == LASTT) begin
          m_mode = M_WAIT; m_blank = 1;
          if (!m_valid) begin m_data = m_cap; nv = 1; end
          else if (m_ovr < 255) m_ovr++;
        end else m_t++;
      end
      default: begin
        if (m_t == LASTT) begin m_mode = M_IDLE; m_running = 0; end else m_t++;
      end
    endcase
    m_valid = nv;
  endtask

  // monitors used by the directed checks
  logic [47:0] wq[$];
  int          rd_cnt = 0;
  logic        prev_wr = 1'b0, prev_rd = 1'b0;

  // Compare DUT against model every cycle, away from the active edge
  always @(negedge clk) begin
    bit          acc, strb, e_rd, e_wr;
    logic [15:0] e_addr;
    logic [31:0] e_wd;
    if (!rst_n) model_reset();
    acc  = (m_mode != M_IDLE) && (m_mode != M_WAIT);
    strb = acc && (m_t >= 1) && (m_t <= S);
    e_rd = strb && (m_mode == M_READ);
    e_wr = strb && (m_mode != M_READ);
    case (m_mode)
      M_CFG:   begin e_addr = cfg_a(m_idx); e_wd = cfg_d(m_idx); end
      M_READ:  begin e_addr = 16'h073C;     e_wd = 32'h0; end
      M_CLEAR: begin e_addr = 16'h0704;     e_wd = P_CLR; end
      default: begin e_addr = 16'h0718;     e_wd = P_OFF; end
    endcase
    chk("RD", {31'h0, RD}, {31'h0, e_rd});
    chk("WR", {31'h0, WR}, {31'h0, e_wr});
    chk("WDATA", WDATA, e_wr ? e_wd : 32'h0);
    if (acc) chk("ADDR", {16'h0, ADDR}, {16'h0, e_addr});
    chk("busy", {31'h0, busy}, {31'h0, (m_mode != M_IDLE)});
    chk("running", {31'h0, running}, {31'h0, m_running});
    chk("smp_valid", {31'h0, smp_valid}, {31'h0, m_valid});
    if (m_valid) chk("smp_data", smp_data, m_data);
    chk("overrun_cnt", {24'h0, overrun_cnt}, m_ovr[31:0]);
    if (WR && !prev_wr) wq.push_back({ADDR, WDATA});
    if (RD && !prev_rd) rd_cnt++;
    prev_wr = WR;
    prev_rd = RD;
    if (rst_n) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(input logic [15:0] a, input string name);
    int n;
    n = 0;
    while (!(WR && ADDR == a) && n < 60) begin tick(); n++; end
    if (n >= 60) begin checks++; failures++; $display("FAIL timeout_%s actual=none expected=WR@%h", name, a); end
  endtask

  task automatic wait_sig(input int which, input logic lvl, input string name);
    int n;
    logic v;
    n = 0;
    v = (which == 0) ? busy : (which == 1) ? running : (which == 2) ? smp_valid : RD;
    while (v !== lvl && n < 60) begin
      tick(); n++;
      v = (which == 0) ? busy : (which == 1) ? running : (which == 2) ? smp_valid : RD;
    end
    if (n >= 60) begin checks++; failures++; $display("FAIL timeout_%s actual=%b expected=%b", name, v, lvl); end
  endtask

  task automatic start_and_measure(input string name);
    int n;
    wq.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!running && n < 100) begin tick(); n++; end
    chk({name, "_latency"}, n, 17);
    chk({name, "_nwr"}, wq.size(), 4);
    if (wq.size() == 4) begin
      chk({name, "_a0"}, {wq[0][47:32], 16'h0}, {16'h0700, 16'h0});
      chk({name, "_a1"}, {wq[1][47:32], 16'h0}, {16'h0710, 16'h0});
      chk({name, "_a2"}, {wq[2][47:32], 16'h0}, {16'h0714, 16'h0});
      chk({name, "_a3"}, {wq[3][47:32], 16'h0}, {16'h0718, 16'h0});
      chk({name, "_d0"}, wq[0][31:0], P_CTL);
      chk({name, "_d3"}, wq[3][31:0], P_FC);
    end
  endtask

  task automatic service(input logic [31:0] v);
    irq = 1'b1;
    rdata = v;
    wait_wr(16'h0704, "flag_clear");
    irq = 1'b0;
    repeat (4) tick();
  endtask

  task automatic ready_pulse();
    smp_ready = 1'b1;
    tick();
    smp_ready = 1'b0;
    chk("valid_after_ready", {31'h0, smp_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] vals[3];
    model_reset();
    repeat (3) tick();
    chk("rst_RD", {31'h0, RD}, 32'h0);
    chk("rst_WR", {31'h0, WR}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_running", {31'h0, running}, 32'h0);
    chk("rst_ovr", {24'h0, overrun_cnt}, 32'h0);
    chk("rst_ADDR", {16'h0, ADDR}, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: config sequence
    start_and_measure("cfg");

    // 2: single IRQ service
    wq.delete(); rd_cnt = 0;
    service(32'h0001_2345);
    wait_sig(2, 1'b1, "smp_valid");
    chk("svc_data", smp_data, 32'h0001_2345);
    chk("svc_rd_cnt", rd_cnt, 1);
    chk("svc_clr_addr", {16'h0, wq[0][47:32]}, 32'h0000_0704);
    chk("svc_clr_data", wq[0][31:0], 32'hFFFF_FFFF);
    ready_pulse();

    // 3: overruns while consumer stalls
    for (int k = 0; k < 3; k++) vals[k] = $urandom;
    for (int k = 0; k < 3; k++) service(vals[k]);
    chk("ovr_data", smp_data, vals[0]);
    chk("ovr_cnt", {24'h0, overrun_cnt}, 32'd2);
    ready_pulse();

    // 4: stop together with IRQ in RUN_WAIT
    repeat (3) tick();
    wq.delete(); rd_cnt = 0;
    stop = 1'b1; irq = 1'b1;
    tick();
    stop = 1'b0; irq = 1'b0;
    wait_sig(0, 1'b0, "busy_low");
    chk("stop_rd_cnt", rd_cnt, 0);
    chk("stop_nwr", wq.size(), 1);
    chk("stop_wr", {wq[0][47:32], 16'h0}, {16'h0718, 16'h0});
    chk("stop_wdata", wq[0][31:0], P_OFF);
    chk("stop_running", {31'h0, running}, 32'h0);

    // 5: start during CFG ignored; stop during read strobe is deferred
    wq.delete();
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_sig(1, 1'b1, "running");
    chk("norestart_nwr", wq.size(), 4);
    wq.delete(); rd_cnt = 0;
    irq = 1'b1; rdata = 32'hA5A5_0F0F;
    wait_sig(3, 1'b1, "rd_strobe");
    stop = 1'b1; tick(); stop = 1'b0;
    wait_wr(16'h0704, "defer_clear");
    irq = 1'b0;
    wait_sig(0, 1'b0, "busy_low2");
    chk("defer_rd_cnt", rd_cnt, 1);
    chk("defer_nwr", wq.size(), 2);
    chk("defer_last", {wq[wq.size()-1][47:32], 16'h0}, {16'h0718, 16'h0});
    chk("defer_valid", {31'h0, smp_valid}, 32'h1);

    // 6: reset mid write strobe, then full reconfiguration
    start = 1'b1; tick(); start = 1'b0;
    wait_wr(16'h0700, "first_cfg_wr");
    #1 rst_n = 1'b0;
    #1;
    chk("arst_WR", {31'h0, WR}, 32'h0);
    chk("arst_RD", {31'h0, RD}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_valid", {31'h0, smp_valid}, 32'h0);
    chk("arst_ovr", {24'h0, overrun_cnt}, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    start_and_measure("recfg");

    // random traffic checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(39) == 0);
      stop      = ($urandom_range(59) == 0);
      smp_ready = ($urandom_range(2) == 0);
      if ($urandom_range(7) == 0) irq = ~irq;
      rdata     = $urandom;
      tick();
    end
    start = 1'b0; stop = 1'b0; irq = 1'b0; smp_ready = 1'b0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
